// File: rtl/std_crc_check.sv
// Receive-side Ethernet FCS checker: runs CRC32 over frame+FCS, strips the 4 FCS
// bytes through a delay line and reports good/bad/runt status at end of frame.

module std_crc32_8b (
  input  logic [31:0] crc_state,
  input  logic [7:0]  data_in,
  output logic [31:0] crc_next
);
  localparam logic [31:0] POLY = 32'hEDB88320;

  logic [31:0] c;

  // Reflected CRC32, one bit per step, LSB of the byte first
  always_comb begin
    c = crc_state;
    for (int i = 0; i < 8; i++) begin
      c = (c[0] ^ data_in[i]) ? ((c >> 1) ^ POLY) : (c >> 1);
    end
  end

  assign crc_next = c;
endmodule

module std_crc_check #(
  parameter logic [31:0] RESIDUE = 32'hDEBB20E3,
  parameter logic [31:0] INIT    = 32'hFFFFFFFF,
  parameter int unsigned LW      = 16
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          s_valid,
  input  logic [7:0]    s_data,
  input  logic          s_last,
  output logic          m_valid,
  output logic [7:0]    m_data,
  output logic          m_last,
  output logic          crc_done,
  output logic          crc_ok,
  output logic          crc_runt,
  output logic [LW-1:0] frame_len
);
  localparam int unsigned FW = 3;

  typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;

  state_t          state, state_nx;
  logic [FW-1:0]   fill, fill_nx;
  logic [3:0][7:0] dly;
  logic [31:0]     crc, crc_in, crc_next;
  logic [LW-1:0]   len, len_inc;

  logic            emit, eof, runt;
  logic            m_valid_d, m_last_d, crc_done_d, crc_ok_d, crc_runt_d;
  logic [7:0]      m_data_d;
  logic [LW-1:0]   frame_len_d;

  assign crc_in  = (state == IDLE) ? INIT : crc;
  assign len_inc = (&len) ? len : len + LW'(1);

  std_crc32_8b u_crc (
    .crc_state (crc_in),
    .data_in   (s_data),
    .crc_next  (crc_next)
  );

  // State register
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state <= IDLE;
      fill  <= '0;
    end else begin
      state <= state_nx;
      fill  <= fill_nx;
    end
  end

  // Next state: fill counts buffered FCS candidates, end of frame returns to IDLE
  always_comb begin
    state_nx = state;
    fill_nx  = fill;
    if (s_valid) begin
      if (s_last) begin
        state_nx = IDLE;
        fill_nx  = '0;
      end else begin
        unique case (state)
          IDLE: begin
            state_nx = FILL;
            fill_nx  = FW'(1);
          end
          FILL: begin
            fill_nx  = fill + FW'(1);
            state_nx = (fill == FW'(3)) ? RUN : FILL;
          end
          RUN:     state_nx = RUN;
          default: state_nx = IDLE;
        endcase
      end
    end
  end

  // Output values: RUN emits the oldest buffered byte; s_last outside RUN is a runt
  always_comb begin
    emit        = s_valid && (state == RUN);
    eof         = s_valid && s_last;
    runt        = eof && (state != RUN);
    m_valid_d   = emit;
    m_data_d    = emit ? dly[3] : m_data;
    m_last_d    = emit && s_last;
    crc_done_d  = eof;
    crc_ok_d    = crc_ok;
    crc_runt_d  = crc_runt;
    frame_len_d = frame_len;
    if (eof) begin
      crc_ok_d    = !runt && (crc_next == RESIDUE);
      crc_runt_d  = runt;
      frame_len_d = runt ? '0 : len_inc;
    end
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      crc       <= INIT;
      dly       <= '0;
      len       <= '0;
      m_valid   <= 1'b0;
      m_data    <= '0;
      m_last    <= 1'b0;
      crc_done  <= 1'b0;
      crc_ok    <= 1'b0;
      crc_runt  <= 1'b0;
      frame_len <= '0;
    end else begin
      if (s_valid) begin
        crc <= crc_next;
        dly <= {dly[2:0], s_data};
      end
      if (eof)       len <= '0;
      else if (emit) len <= len_inc;
      m_valid   <= m_valid_d;
      m_data    <= m_data_d;
      m_last    <= m_last_d;
      crc_done  <= crc_done_d;
      crc_ok    <= crc_ok_d;
      crc_runt  <= crc_runt_d;
      frame_len <= frame_len_d;
    end
  end
endmodule

// File: tb/tb_std_crc_check.sv
// Directed bench for std_crc_check using the "123456789" Ethernet frame.

module tb_std_crc_check;
  logic        clk = 1'b0;
  logic        nreset = 1'b0;
  logic        s_valid = 1'b0;
  logic [7:0]  s_data = 8'h00;
  logic        s_last = 1'b0;
  logic        m_valid;
  logic [7:0]  m_data;
  logic        m_last;
  logic        crc_done;
  logic        crc_ok;
  logic        crc_runt;
  logic [15:0] frame_len;

  int total = 0;
  int bad = 0;
  int gap_err = 0;
  logic prev_valid = 1'b0;

  logic [8:0]  out_q[$];
  logic [17:0] stat_q[$];
  logic [7:0]  tx[13];
  logic [7:0]  good[13] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38,
                            8'h39, 8'h26, 8'h39, 8'hF4, 8'hCB};

  std_crc_check dut (
    .clk       (clk),
    .nreset    (nreset),
    .s_valid   (s_valid),
    .s_data    (s_data),
    .s_last    (s_last),
    .m_valid   (m_valid),
    .m_data    (m_data),
    .m_last    (m_last),
    .crc_done  (crc_done),
    .crc_ok    (crc_ok),
    .crc_runt  (crc_runt),
    .frame_len (frame_len)
  );

  always #5 clk = ~clk;

  always @(posedge clk) prev_valid <= s_valid;

  // Collect outputs mid-cycle; flag any beat/status that follows a gap cycle
  always @(negedge clk) begin
    if (m_valid) out_q.push_back({m_last, m_data});
    if (crc_done) stat_q.push_back({crc_ok, crc_runt, frame_len});
    if ((m_valid || crc_done) && !prev_valid) gap_err++;
  end

  task automatic drive(input logic [7:0] d, input logic l);
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      s_valid = 1'b0;
      s_last  = 1'b0;
    end
  endtask

  task automatic send(input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps && i > 0) idle($urandom_range(1, 3));
      drive(tx[i], i == n - 1);
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    total++; if ({m_valid, m_last, crc_done} !== 3'b000) begin bad++; $display("FAIL reset_ctl got=%b want=000", {m_valid, m_last, crc_done}); end
    total++; if (m_data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h want=00", m_data); end
    total++; if ({crc_ok, crc_runt, frame_len} !== 18'h0) begin bad++; $display("FAIL reset_stat got=%h want=0", {crc_ok, crc_runt, frame_len}); end
    nreset = 1'b1;
    idle(2);
  endtask

  task automatic test_good;
    tx = good;
    out_q.delete(); stat_q.delete();
    send(13, 1'b0); idle(3);
    total++; if (out_q.size() !== 9) begin bad++; $display("FAIL good_count got=%0d want=9", out_q.size()); end
    for (int i = 0; i < 9 && out_q.size() > 0; i++) begin
      logic [8:0] o = out_q.pop_front();
      total++; if (o !== {i == 8, good[i]}) begin bad++; $display("FAIL good_byte%0d got=%h want=%h", i, o, {i == 8, good[i]}); end
    end
    total++; if (stat_q.size() !== 1) begin bad++; $display("FAIL good_done got=%0d want=1", stat_q.size()); end
    else begin total++; if (stat_q[0] !== {2'b10, 16'd9}) begin bad++; $display("FAIL good_stat got=%h want=%h", stat_q[0], {2'b10, 16'd9}); end end
  endtask

  task automatic test_bad_fcs;
    tx = good;
    tx[12] = 8'hCA;
    out_q.delete(); stat_q.delete();
    send(13, 1'b0); idle(3);
    total++; if (out_q.size() !== 9) begin bad++; $display("FAIL badfcs_count got=%0d want=9", out_q.size()); end
    for (int i = 0; i < 9 && out_q.size() > 0; i++) begin
      logic [8:0] o = out_q.pop_front();
      total++; if (o !== {i == 8, good[i]}) begin bad++; $display("FAIL badfcs_byte%0d got=%h want=%h", i, o, {i == 8, good[i]}); end
    end
    total++; if (stat_q.size() !== 1) begin bad++; $display("FAIL badfcs_done got=%0d want=1", stat_q.size()); end
    else begin total++; if (stat_q[0] !== {2'b00, 16'd9}) begin bad++; $display("FAIL badfcs_stat got=%h want=%h", stat_q[0], {2'b00, 16'd9}); end end
  endtask

  task automatic test_gaps;
    tx = good;
    out_q.delete(); stat_q.delete();
    gap_err = 0;
    send(13, 1'b1); idle(3);
    total++; if (gap_err !== 0) begin bad++; $display("FAIL gaps_output_in_gap got=%0d want=0", gap_err); end
    total++; if (out_q.size() !== 9) begin bad++; $display("FAIL gaps_count got=%0d want=9", out_q.size()); end
    for (int i = 0; i < 9 && out_q.size() > 0; i++) begin
      logic [8:0] o = out_q.pop_front();
      total++; if (o !== {i == 8, good[i]}) begin bad++; $display("FAIL gaps_byte%0d got=%h want=%h", i, o, {i == 8, good[i]}); end
    end
    total++; if (stat_q.size() !== 1) begin bad++; $display("FAIL gaps_done got=%0d want=1", stat_q.size()); end
    else begin total++; if (stat_q[0] !== {2'b10, 16'd9}) begin bad++; $display("FAIL gaps_stat got=%h want=%h", stat_q[0], {2'b10, 16'd9}); end end
  endtask

  task automatic test_back_to_back;
    tx = good;
    out_q.delete(); stat_q.delete();
    send(13, 1'b0); send(13, 1'b0); idle(3);
    total++; if (out_q.size() !== 18) begin bad++; $display("FAIL b2b_count got=%0d want=18", out_q.size()); end
    for (int i = 0; i < 18 && out_q.size() > 0; i++) begin
      logic [8:0] o = out_q.pop_front();
      total++; if (o !== {(i % 9) == 8, good[i % 9]}) begin bad++; $display("FAIL b2b_byte%0d got=%h want=%h", i, o, {(i % 9) == 8, good[i % 9]}); end
    end
    total++; if (stat_q.size() !== 2) begin bad++; $display("FAIL b2b_done got=%0d want=2", stat_q.size()); end
    else begin
      for (int f = 0; f < 2; f++) begin
        total++; if (stat_q[f] !== {2'b10, 16'd9}) begin bad++; $display("FAIL b2b_stat%0d got=%h want=%h", f, stat_q[f], {2'b10, 16'd9}); end
      end
    end
  endtask

  task automatic test_runt;
    tx = good;
    out_q.delete(); stat_q.delete();
    send(1, 1'b0); idle(2);
    send(4, 1'b0); idle(3);
    total++; if (out_q.size() !== 0) begin bad++; $display("FAIL runt_mvalid got=%0d want=0", out_q.size()); end
    total++; if (stat_q.size() !== 2) begin bad++; $display("FAIL runt_done got=%0d want=2", stat_q.size()); end
    else begin
      for (int f = 0; f < 2; f++) begin
        total++; if (stat_q[f] !== {2'b01, 16'd0}) begin bad++; $display("FAIL runt_stat%0d got=%h want=%h", f, stat_q[f], {2'b01, 16'd0}); end
      end
    end
    stat_q.delete();
    send(13, 1'b0); idle(3);
    total++; if (out_q.size() !== 9) begin bad++; $display("FAIL runt_next_count got=%0d want=9", out_q.size()); end
    total++; if (stat_q.size() !== 1 || stat_q[0] !== {2'b10, 16'd9}) begin bad++; $display("FAIL runt_next_stat got=%0d/%h want=1/%h", stat_q.size(), (stat_q.size() > 0) ? stat_q[0] : 18'h0, {2'b10, 16'd9}); end
  endtask

  task automatic test_reset_mid;
    tx = good;
    send(6, 1'b0);
    @(negedge clk);
    nreset = 1'b0;
    s_valid = 1'b0;
    s_last = 1'b0;
    #1;
    total++; if ({m_valid, m_data, m_last, crc_done} !== 11'h0) begin bad++; $display("FAIL rstmid_outputs got=%h want=0", {m_valid, m_data, m_last, crc_done}); end
    idle(2);
    total++; if ({crc_ok, crc_runt, frame_len} !== 18'h0) begin bad++; $display("FAIL rstmid_stat got=%h want=0", {crc_ok, crc_runt, frame_len}); end
    out_q.delete(); stat_q.delete();
    nreset = 1'b1;
    idle(2);
    send(13, 1'b0); idle(3);
    total++; if (out_q.size() !== 9) begin bad++; $display("FAIL rstmid_count got=%0d want=9", out_q.size()); end
    for (int i = 0; i < 9 && out_q.size() > 0; i++) begin
      logic [8:0] o = out_q.pop_front();
      total++; if (o !== {i == 8, good[i]}) begin bad++; $display("FAIL rstmid_byte%0d got=%h want=%h", i, o, {i == 8, good[i]}); end
    end
    total++; if (stat_q.size() !== 1 || stat_q[0] !== {2'b10, 16'd9}) begin bad++; $display("FAIL rstmid_stat2 got=%0d/%h want=1/%h", stat_q.size(), (stat_q.size() > 0) ? stat_q[0] : 18'h0, {2'b10, 16'd9}); end
  endtask

  initial begin
    test_reset;
    test_good;
    test_bad_fcs;
    test_gaps;
    test_back_to_back;
    test_runt;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
